weight_chain_sequencer: RTL
===========================

WEIGHT_CHAIN_SEQUENCER -- requirements
Module: weight_chain_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the value and result width.
REQ-002 SHALL have parameter WEIGHT_AMOUNT, default 4, the values per input vector, equal to the cells' WEIGHT_AMOUNT.
REQ-003 SHALL have parameter NUM_CELLS, default 4, the number of weight computation cells chained behind this block.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, the result FIFO entries; FIFO_DEPTH >= NUM_CELLS is required.
REQ-005 SHALL have ports: clk, in, 1, the only clock; reset_n, in, 1, synchronous active-low reset.
REQ-006 SHALL have ports: in_value, in, DATA_WIDTH, vector element; in_valid, in, 1; in_ready, out, 1.
REQ-007 SHALL have ports: chain_index, out, DATA_WIDTH; chain_value, out, DATA_WIDTH; chain_enable, out, 1; chain_result_seed, out, DATA_WIDTH+1. These drive the first cell.
REQ-008 SHALL have port chain_result, in, DATA_WIDTH+1, taken from the last cell; the MSB is the result-valid flag.
REQ-009 SHALL have ports: res_data, out, DATA_WIDTH; res_valid, out, 1; res_ready, in, 1.
REQ-010 SHALL have status ports: busy, out, 1; overflow, out, 1, sticky; credits, out, $clog2(FIFO_DEPTH+1).

Function
REQ-011 SHALL run an FSM with states INIT, IDLE and STREAM; INIT lasts exactly 1 cycle after reset and then moves to IDLE.
REQ-012 SHALL hold in_ready=0 and chain_enable=0 in INIT, so the cells see enable 0 before the first beat.
REQ-013 SHALL hold a beat counter idx from 0 to WEIGHT_AMOUNT-1; a beat transfers when in_valid and in_ready are both 1.
REQ-014 SHALL, in IDLE, or in STREAM with idx=0, assert in_ready only when credits >= NUM_CELLS (vector admission).
REQ-015 SHALL, in STREAM with idx>0, assert in_ready=1 unconditionally, so a vector never stalls on credits once admitted.
REQ-016 SHALL subtract NUM_CELLS from credits on each admitted beat with idx=0.
REQ-017 SHALL add 1 to credits on each result pop (res_valid and res_ready both 1); when admission and pop fall in the same cycle, the net change is 1-NUM_CELLS.
REQ-018 SHALL register chain outputs on every transferred beat: chain_value=in_value, chain_index=idx, chain_enable=1, giving a latency of 1 cycle from beat to chain.
REQ-019 SHALL drive chain_enable=0, chain_index=0 and chain_value=0 on cycles without a transfer, including bubbles in the middle of a vector; idx holds.
REQ-020 SHALL wrap idx from WEIGHT_AMOUNT-1 to 0 after the last beat; the FSM goes to STREAM on the first beat and stays there for back-to-back vectors.
REQ-021 SHALL move from STREAM to IDLE when the last beat of a vector transfers and no beat with idx=0 transfers in the next cycle.
REQ-022 SHALL tie chain_result_seed to constant 0.
REQ-023 SHALL push chain_result[DATA_WIDTH-1:0] into the FIFO on each cycle where chain_result[DATA_WIDTH]=1.
REQ-024 SHALL, on a push while the FIFO is full with no pop in that cycle, drop the data and set overflow=1 until reset; a push and pop in the same cycle on a full FIFO SHALL succeed.
REQ-025 SHALL make the FIFO first-word-fall-through: res_valid = not empty, res_data = head entry, results in arrival order.
REQ-026 SHALL assert busy=1 when the FSM is not in IDLE, or credits < FIFO_DEPTH.

Reset
REQ-027 SHALL, when reset_n=0 at a clk edge, including during a vector, set: FSM=INIT, idx=0, credits=FIFO_DEPTH, FIFO empty, overflow=0.
REQ-028 SHALL, on the same edge, zero all chain outputs and set in_ready=0, res_valid=0 and busy=1; a partly sent vector is discarded.

Structure
REQ-029 SHALL place the FSM state encoding and the FIFO/credit width helper in the shared package wcs_pkg.
REQ-030 SHALL implement the result FIFO as the sub-module wcs_result_fifo, parameterised by DATA_WIDTH and FIFO_DEPTH, with push, pop, full and empty.

Verification
REQ-031 SHALL cover reset release: the cycle after reset_n rises has in_ready=0 and chain_enable=0; the next cycle has in_ready=1 and credits=8.
REQ-032 SHALL cover one vector {1,2,3,4} with all cell weights 1: chain_index 0,1,2,3 on 4 consecutive cycles, 1 cycle after each beat; then 4 results of 10, popped with credits back to 8.
REQ-033 SHALL cover backpressure: res_ready=0, FIFO_DEPTH=8, NUM_CELLS=4; 2 vectors admitted, the 3rd held with in_ready=0 at idx=0; one pop leaves it held, four pops admit it.
REQ-034 SHALL cover a mid-vector bubble: in_valid low for 3 cycles after beat idx=1; chain_enable=0 for 3 cycles, the next beat goes out with idx=2, and results equal the no-bubble case.
REQ-035 SHALL cover reset mid-vector: reset_n=0 after beat idx=2; next cycle all chain outputs are 0, FIFO empty, credits=8, FSM in INIT.
REQ-036 SHALL cover overflow: chain_result pulsed with the valid MSB on 9 cycles, res_ready=0, FIFO_DEPTH=8; overflow=1 after the 9th pulse, FIFO holds the first 8.

Source files
------------

// File: rtl/wcs_pkg.sv
// Shared types and width helpers for the weight chain sequencer.
package wcs_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_STREAM = 2'd2
  } wcs_state_e;

  // Width of a counter that must hold every value 0..depth inclusive
  // (FIFO fill level and credit counter).
  function automatic int wcs_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of an index that addresses 0..count-1, never narrower than 1 bit
  // (FIFO pointers and the beat counter).
  function automatic int wcs_idx_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/wcs_result_fifo.sv
// First-word-fall-through result FIFO. The head entry is always visible on
// o_data while o_empty is low. A push into a full FIFO is accepted only when a
// pop happens on the same edge; otherwise the data is dropped.
module wcs_result_fifo
  import wcs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int PW = wcs_idx_w(FIFO_DEPTH);
  localparam int CW = wcs_cnt_w(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~w_empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and fill level, wrapping at FIFO_DEPTH (not necessarily a power of 2).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/weight_chain_sequencer.sv
// Feeds input vectors beat by beat into a chain of weight computation cells
// and collects the chain's results into a FIFO. Admission of a new vector is
// gated by credits so that every admitted vector is guaranteed FIFO space for
// its NUM_CELLS results; FIFO_DEPTH must be at least NUM_CELLS.
//
// Handshakes (in_* and res_*): a transfer happens on a rising clk edge where
// valid and ready are both 1. The sender holds valid and data stable until the
// transfer. Ready never depends on valid on the same interface, so there is no
// combinational loop with the neighbour.
module weight_chain_sequencer
  import wcs_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int WEIGHT_AMOUNT = 4,
  parameter int NUM_CELLS     = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [DATA_WIDTH-1:0]              in_value,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [DATA_WIDTH-1:0]              chain_index,
  output logic [DATA_WIDTH-1:0]              chain_value,
  output logic                               chain_enable,
  output logic [DATA_WIDTH:0]                chain_result_seed,
  input  logic [DATA_WIDTH:0]                chain_result,
  output logic [DATA_WIDTH-1:0]              res_data,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic                               busy,
  output logic                               overflow,
  output logic [wcs_cnt_w(FIFO_DEPTH)-1:0]   credits,
  output wcs_state_e                         dbg_state
);

  localparam int CW = wcs_cnt_w(FIFO_DEPTH);
  localparam int IW = wcs_idx_w(WEIGHT_AMOUNT);
  localparam logic [IW-1:0] IDX_LAST  = IW'(WEIGHT_AMOUNT - 1);
  localparam logic [CW-1:0] CRED_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CRED_VEC  = CW'(NUM_CELLS);

  wcs_state_e            r_state;
  wcs_state_e            w_state_next;
  logic [IW-1:0]         r_idx;
  logic [CW-1:0]         r_credits;
  logic [DATA_WIDTH-1:0] r_chain_index;
  logic [DATA_WIDTH-1:0] r_chain_value;
  logic                  r_chain_enable;
  logic                  r_overflow;

  logic                  w_in_ready;
  logic                  w_credit_ok;
  logic                  w_beat;
  logic                  w_admit;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [DATA_WIDTH-1:0] w_fifo_data;

  assign w_credit_ok = (r_credits >= CRED_VEC);
  assign w_beat      = in_valid & w_in_ready;
  // The first beat of a vector is the one that reserves FIFO space.
  assign w_admit     = w_beat & (r_idx == '0);
  assign w_push      = chain_result[DATA_WIDTH];
  assign w_pop       = res_valid & res_ready;

  // Next-state and in_ready decode. Mid-vector beats are never credit gated,
  // so an admitted vector streams without stalls from this block.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        w_in_ready = w_credit_ok;
        if (in_valid && w_credit_ok) begin
          w_state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        w_in_ready = (r_idx != '0) ? 1'b1 : w_credit_ok;
        // idx is 0 in STREAM only on the cycle right after a vector's last
        // beat; without a new first beat there, fall back to IDLE.
        if ((r_idx == '0) && !(in_valid && w_credit_ok)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Beat counter: advances per transferred beat, wraps after the last one,
  // holds across bubbles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_idx <= '0;
    end else if (w_beat) begin
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end
  end

  // Credit counter: a vector's worth is reserved at admission, one credit
  // returns per popped result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_credits <= CRED_FULL;
    end else begin
      r_credits <= r_credits - (w_admit ? CRED_VEC : '0) + (w_pop ? CW'(1) : '0);
    end
  end

  // Chain drive: one registered stage per beat, all-zero on idle cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_chain_enable <= 1'b0;
      r_chain_index  <= '0;
      r_chain_value  <= '0;
    end else begin
      r_chain_enable <= w_beat;
      r_chain_index  <= w_beat ? DATA_WIDTH'(r_idx) : '0;
      r_chain_value  <= w_beat ? in_value : '0;
    end
  end

  // Sticky flag for a result lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_fifo_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  wcs_result_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_data  (chain_result[DATA_WIDTH-1:0]),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign in_ready          = w_in_ready;
  assign chain_index       = r_chain_index;
  assign chain_value       = r_chain_value;
  assign chain_enable      = r_chain_enable;
  assign chain_result_seed = '0;
  assign res_data          = w_fifo_data;
  assign res_valid         = ~w_fifo_empty;
  assign busy              = (r_state != ST_IDLE) || (r_credits < CRED_FULL);
  assign overflow          = r_overflow;
  assign credits           = r_credits;
  assign dbg_state         = r_state;

endmodule
